lane_direction_detector: RTL

//  Upstream stage of the lot-occupancy counter. Decodes two raw beam sensors

---
 rtl/parking_pkg.sv | 22 ++
 rtl/beam_filter.sv | 46 ++++
 rtl/lane_direction_detector.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared types for the lane direction detector: FSM state encoding and
// filtered beam codes, packed as {beam_a, beam_b}.
package parking_pkg;

  typedef enum logic [3:0] {
    IDLE,
    IN1,
    IN2,
    IN3,
    OUT1,
    OUT2,
    OUT3,
    AMBIG,
    FAULT
  } lane_state_e;

  localparam logic [1:0] BEAM_CLEAR  = 2'b00;
  localparam logic [1:0] BEAM_A_ONLY = 2'b10;
  localparam logic [1:0] BEAM_B_ONLY = 2'b01;
  localparam logic [1:0] BEAM_BOTH   = 2'b11;

endpackage

// File: rtl/beam_filter.sv
// Two-flop synchronizer followed by a debounce filter: the filtered output
// only follows the synchronized beam after DEBOUNCE_CYCLES consecutive differing samples.
module beam_filter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic beam_raw,
  output logic beam_filt
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // The run counter restarts whenever the sample agrees with the filtered value.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], beam_raw};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign beam_filt = filt_q;

endmodule

// File: rtl/lane_direction_detector.sv
// Decodes two lane beams into entry/exit pulses with back-out rejection and
// stuck-beam timeout. Optional pass totals under VEHICLE_COUNT_EN.
module lane_direction_detector
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             beam_a_raw,
  input  logic             beam_b_raw,
  output logic             entry_pulse,
  output logic             exit_pulse,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] entry_total,
  output logic [CNT_W-1:0] exit_total
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0] raw_vec, beams;
  assign raw_vec = {beam_a_raw, beam_b_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_beam
      beam_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter (
        .clk       (clk),
        .reset     (reset),
        .beam_raw  (raw_vec[gi]),
        .beam_filt (beams[gi])
      );
    end
  endgenerate

  lane_state_e   state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          entry_q, entry_d, exit_q, exit_d;
  logic          timed;

  always_comb begin
    state_d = state_q;
    timed   = (state_q != IDLE) && (state_q != FAULT);
    case (state_q)
      IDLE:  case (beams)
               BEAM_A_ONLY: state_d = IN1;
               BEAM_B_ONLY: state_d = OUT1;
               BEAM_BOTH:   state_d = AMBIG;
               default:     state_d = IDLE;
             endcase
      IN1:   case (beams)
               BEAM_BOTH:   state_d = IN2;
               BEAM_CLEAR:  state_d = IDLE;
               BEAM_B_ONLY: state_d = AMBIG;
               default:     state_d = IN1;
             endcase
      IN2:   case (beams)
               BEAM_B_ONLY: state_d = IN3;
               BEAM_A_ONLY: state_d = IN1;
               BEAM_CLEAR:  state_d = AMBIG;
               default:     state_d = IN2;
             endcase
      IN3:   case (beams)
               BEAM_CLEAR:  state_d = IDLE;
               BEAM_BOTH:   state_d = IN2;
               BEAM_A_ONLY: state_d = AMBIG;
               default:     state_d = IN3;
             endcase
      OUT1:  case (beams)
               BEAM_BOTH:   state_d = OUT2;
               BEAM_CLEAR:  state_d = IDLE;
               BEAM_A_ONLY: state_d = AMBIG;
               default:     state_d = OUT1;
             endcase
      OUT2:  case (beams)
               BEAM_A_ONLY: state_d = OUT3;
               BEAM_B_ONLY: state_d = OUT1;
               BEAM_CLEAR:  state_d = AMBIG;
               default:     state_d = OUT2;
             endcase
      OUT3:  case (beams)
               BEAM_CLEAR:  state_d = IDLE;
               BEAM_BOTH:   state_d = OUT2;
               BEAM_B_ONLY: state_d = AMBIG;
               default:     state_d = OUT3;
             endcase
      AMBIG, FAULT: if (beams == BEAM_CLEAR) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A stalled pass overrides whatever the beams did this cycle.
    if (timed && (tmo_q == TMO_LAST)) state_d = FAULT;

    entry_d = (state_q == IN3)  && (state_d == IDLE);
    exit_d  = (state_q == OUT3) && (state_d == IDLE);

    tmo_d = tmo_q;
    if (state_d != state_q)              tmo_d = '0;
    else if (timed && tmo_q != TMO_LAST) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      entry_q <= entry_d;
      exit_q  <= exit_d;
    end
  end

  assign entry_pulse = entry_q;
  assign exit_pulse  = exit_q;
  assign busy        = (state_q != IDLE);
  assign fault       = (state_q == FAULT);

`ifdef VEHICLE_COUNT_EN
  logic [CNT_W-1:0] entry_cnt_q, exit_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_cnt_q <= '0;
      exit_cnt_q  <= '0;
    end else begin
      if (entry_q && !(&entry_cnt_q)) entry_cnt_q <= entry_cnt_q + 1'b1;
      if (exit_q && !(&exit_cnt_q))   exit_cnt_q  <= exit_cnt_q + 1'b1;
    end
  end

  assign entry_total = entry_cnt_q;
  assign exit_total  = exit_cnt_q;
`else
  assign entry_total = '0;
  assign exit_total  = '0;
`endif

endmodule
